ram_acc_sequencer: RTL
======================

RAM_ACC_SEQUENCER -- requirements
Module: ram_acc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 2, SHALL set RAM address width; word count N = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 3, SHALL set word width for RAM data and accumulator.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  run request, sampled on rising edge in IDLE or DONE.
REQ-006 gen_data  in  DATA_W  current word_gen output, the word being written to RAM.
REQ-007 acc_out  in  DATA_W  accumulator Output, the value under check.
REQ-008 gen_next  out  1  advance request to word_gen, one cycle per word.
REQ-009 address  out  ADDR_W  RAM address.
REQ-010 cs, we, oe  out  1 each  RAM chip select, write enable and output enable.
REQ-011 acc_reset  out  1  accumulator clear.
REQ-012 busy  out  1  high from first WRITE cycle through CHECK.
REQ-013 done  out  1  high in DONE.
REQ-014 pass  out  1  check result, valid while done=1.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE, ADV, CLR, READ, CHECK and DONE.
REQ-016 IDLE SHALL hold all outputs 0; start=1 SHALL move to WRITE with address=0 and expected sum exp=0.
REQ-017 WRITE SHALL last 1 cycle with cs=1, we=1, oe=0, gen_next=0, and SHALL capture exp <= (exp + gen_data) mod 2**DATA_W.
REQ-018 ADV SHALL last 1 cycle with cs=0, we=0, gen_next=1; address SHALL increment mod N at the end of ADV.
REQ-019 From ADV, the FSM SHALL go to WRITE if address was < N-1, else to CLR; after the wrap, address SHALL read 0.
REQ-020 CLR SHALL last 1 cycle with acc_reset=1, cs=0, we=0, oe=0.
REQ-021 READ SHALL last N cycles with cs=1, oe=1, we=0 and address = 0,1,...,N-1 on successive cycles; after the last read, address SHALL wrap to 0.
REQ-022 CHECK SHALL last 1 cycle with cs=oe=0 and SHALL register pass <= (acc_out == exp).
REQ-023 DONE SHALL hold done=1, busy=0 and pass stable until start or reset.
REQ-024 start=1 in DONE SHALL clear done and pass and begin a new run in WRITE, exactly as from IDLE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 Latency from the start edge to done=1 SHALL be 2N+N+3 cycles (15 for N=4).
REQ-027 we and oe SHALL never be 1 in the same cycle; we=1 or oe=1 SHALL imply cs=1.
REQ-028 Arithmetic SHALL be unsigned, mod 2**DATA_W, with carry discarded, matching the accumulator.

Reset
REQ-029 Asserting reset SHALL, without waiting for a clock edge, force IDLE, address=0, exp=0, and gen_next, cs, we, oe, acc_reset, busy, done and pass to 0.
REQ-030 Reset mid-run SHALL abandon the run; no RAM write SHALL occur while reset is high.
REQ-031 After reset is released, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-032 word_gen sequence 010,111,011,100 plus a correct accumulator: exp=000; done=1 at cycle 15; pass=1.
REQ-033 Same stimulus, with acc_out forced to 001 during CHECK: pass=0, done=1.
REQ-034 gen_data held at 111 for all writes: exp=100 (28 mod 8); correct accumulator gives pass=1.
REQ-035 Reset asserted asynchronously during the third WRITE: all outputs drop to 0 immediately; a later start reruns from address 0.
REQ-036 start pulsed during READ: it is ignored and latency stays at 15; start in DONE clears done the next cycle and restarts.
REQ-037 On every cycle of every scenario: no cycle with we&oe, and no cycle with (we|oe)&!cs.

Source files
------------

// File: rtl/ram_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_acc_sequencer
// Brief    : Fills a RAM from a word generator, then reads it back through an
//            external accumulator and checks the total against a running sum.
// Revision : 1.0 - initial release
// ============================================================================
module ram_acc_sequencer #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] gen_data,
    input  logic [DATA_W-1:0] acc_out,
    output logic              gen_next,
    output logic [ADDR_W-1:0] address,
    output logic              cs,
    output logic              we,
    output logic              oe,
    output logic              acc_reset,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WRITE = 3'd1;
    localparam logic [2:0] c_ADV   = 3'd2;
    localparam logic [2:0] c_CLR   = 3'd3;
    localparam logic [2:0] c_READ  = 3'd4;
    localparam logic [2:0] c_CHECK = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] exp_q,   exp_d;
    logic              pass_q,  pass_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
            addr_q  <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    // Address counter wraps naturally, so it is back at 0 after both passes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        case (state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    state_d = c_WRITE;
                    addr_d  = '0;
                    exp_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            c_WRITE: begin
                exp_d   = exp_q + gen_data;
                state_d = c_ADV;
            end
            c_ADV: begin
                addr_d  = addr_q + 1'b1;
                state_d = (addr_q == c_ADDR_LAST) ? c_CLR : c_WRITE;
            end
            c_CLR: begin
                state_d = c_READ;
            end
            c_READ: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == c_ADDR_LAST) begin
                    state_d = c_CHECK;
                end
            end
            c_CHECK: begin
                pass_d  = (acc_out == exp_q);
                state_d = c_DONE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_comb begin
        gen_next  = 1'b0;
        cs        = 1'b0;
        we        = 1'b0;
        oe        = 1'b0;
        acc_reset = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            c_WRITE: begin
                cs   = 1'b1;
                we   = 1'b1;
                busy = 1'b1;
            end
            c_ADV: begin
                gen_next = 1'b1;
                busy     = 1'b1;
            end
            c_CLR: begin
                acc_reset = 1'b1;
                busy      = 1'b1;
            end
            c_READ: begin
                cs   = 1'b1;
                oe   = 1'b1;
                busy = 1'b1;
            end
            c_CHECK: begin
                busy = 1'b1;
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign address = addr_q;
    assign pass    = pass_q;

endmodule
`default_nettype wire
